// File: rtl/pic_bus_if.sv
// Host-bus front end and ICW/OCW sequencer for the PIC.
// Syncs the async bus, decodes writes, holds config, muxes read-back.
module pic_bus_if #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             wr_n,
  input  logic             rd_n,
  input  logic             a0,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             dout_oe,
  input  logic [N_IRQ-1:0] irr,
  input  logic [N_IRQ-1:0] isr,
  input  logic             poll_valid,
  input  logic [2:0]       poll_level,
  output logic [N_IRQ-1:0] imr,
  output logic             init_done,
  output logic             ltim,
  output logic             single,
  output logic [4:0]       vec_base,
  output logic [7:0]       cas_cfg,
  output logic             aeoi,
  output logic             upm,
  output logic             smm,
  output logic             ocw2_stb,
  output logic [2:0]       ocw2_cmd,
  output logic [2:0]       ocw2_lvl,
  output logic             poll_stb
);

  localparam int S = SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_ICW2,
    ST_ICW3,
    ST_ICW4,
    ST_READY
  } state_t;

  logic [S-1:0] cs_sh;
  logic [S-1:0] wr_sh;
  logic [S-1:0] rd_sh;
  logic [S-1:0] a0_sh;
  logic [7:0]   din_sh [S];

  logic       cs_s;
  logic       wr_s;
  logic       rd_s;
  logic       a0_s;
  logic [7:0] din_s;

  logic       cs_q;
  logic       wr_q;
  logic       a0_q;
  logic [7:0] din_q;
  logic       wr_arm;
  logic       rd_arm;
  logic       wr_evt;
  logic       wr_a0;
  logic [7:0] wr_dat;
  logic       rd_act_q;

  logic       read_act;
  logic       wr_rise;
  logic       rd_end;
  logic [7:0] rd_word;

  state_t           state;
  state_t           state_nx;
  logic             ic4;
  logic             read_sel;
  logic             poll_pend;

  logic [N_IRQ-1:0] imr_nx;
  logic             init_done_nx;
  logic             ltim_nx;
  logic             single_nx;
  logic             ic4_nx;
  logic [4:0]       vec_base_nx;
  logic [7:0]       cas_cfg_nx;
  logic             aeoi_nx;
  logic             upm_nx;
  logic             smm_nx;
  logic             ocw2_stb_nx;
  logic [2:0]       ocw2_cmd_nx;
  logic [2:0]       ocw2_lvl_nx;
  logic             poll_stb_nx;
  logic             read_sel_nx;
  logic             poll_pend_nx;

  // Strobes reset to "asserted" so a strobe held across reset
  // never looks like a fresh falling edge; cs resets inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sh <= '1;
      wr_sh <= '0;
      rd_sh <= '0;
      a0_sh <= '0;
      for (int i = 0; i < S; i++) din_sh[i] <= '0;
    end else begin
      cs_sh     <= {cs_sh[S-2:0], cs_n};
      wr_sh     <= {wr_sh[S-2:0], wr_n};
      rd_sh     <= {rd_sh[S-2:0], rd_n};
      a0_sh     <= {a0_sh[S-2:0], a0};
      din_sh[0] <= din;
      for (int i = 1; i < S; i++) din_sh[i] <= din_sh[i-1];
    end
  end

  assign cs_s  = cs_sh[S-1];
  assign wr_s  = wr_sh[S-1];
  assign rd_s  = rd_sh[S-1];
  assign a0_s  = a0_sh[S-1];
  assign din_s = din_sh[S-1];

  // A strobe only counts once its pin has been seen high after reset.
  assign read_act = rd_arm & ~rd_s & ~cs_s & wr_s;
  assign wr_rise  = ~wr_q & wr_s & wr_arm & ~cs_q;
  assign rd_end   = rd_act_q & rd_s;

  // Edge detection; the write event and its data are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q     <= 1'b1;
      wr_q     <= 1'b0;
      a0_q     <= 1'b0;
      din_q    <= '0;
      wr_arm   <= 1'b0;
      rd_arm   <= 1'b0;
      wr_evt   <= 1'b0;
      wr_a0    <= 1'b0;
      wr_dat   <= '0;
      rd_act_q <= 1'b0;
    end else begin
      cs_q     <= cs_s;
      wr_q     <= wr_s;
      a0_q     <= a0_s;
      din_q    <= din_s;
      wr_arm   <= wr_arm | wr_s;
      rd_arm   <= rd_arm | rd_s;
      wr_evt   <= wr_rise;
      wr_a0    <= a0_q;
      wr_dat   <= din_q;
      rd_act_q <= read_act;
    end
  end

  // Sequencer state and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_UNINIT;
      imr       <= '1;
      init_done <= 1'b0;
      ltim      <= 1'b0;
      single    <= 1'b0;
      ic4       <= 1'b0;
      vec_base  <= '0;
      cas_cfg   <= '0;
      aeoi      <= 1'b0;
      upm       <= 1'b0;
      smm       <= 1'b0;
      ocw2_stb  <= 1'b0;
      ocw2_cmd  <= '0;
      ocw2_lvl  <= '0;
      poll_stb  <= 1'b0;
      read_sel  <= 1'b0;
      poll_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      imr       <= imr_nx;
      init_done <= init_done_nx;
      ltim      <= ltim_nx;
      single    <= single_nx;
      ic4       <= ic4_nx;
      vec_base  <= vec_base_nx;
      cas_cfg   <= cas_cfg_nx;
      aeoi      <= aeoi_nx;
      upm       <= upm_nx;
      smm       <= smm_nx;
      ocw2_stb  <= ocw2_stb_nx;
      ocw2_cmd  <= ocw2_cmd_nx;
      ocw2_lvl  <= ocw2_lvl_nx;
      poll_stb  <= poll_stb_nx;
      read_sel  <= read_sel_nx;
      poll_pend <= poll_pend_nx;
    end
  end

  // Write decode: ICW1 restarts from any state, else per-state handling.
  always_comb begin
    state_nx     = state;
    imr_nx       = imr;
    init_done_nx = init_done;
    ltim_nx      = ltim;
    single_nx    = single;
    ic4_nx       = ic4;
    vec_base_nx  = vec_base;
    cas_cfg_nx   = cas_cfg;
    aeoi_nx      = aeoi;
    upm_nx       = upm;
    smm_nx       = smm;
    ocw2_stb_nx  = 1'b0;
    ocw2_cmd_nx  = ocw2_cmd;
    ocw2_lvl_nx  = ocw2_lvl;
    poll_stb_nx  = 1'b0;
    read_sel_nx  = read_sel;
    poll_pend_nx = poll_pend;

    if (rd_end && poll_pend) begin
      poll_pend_nx = 1'b0;
      poll_stb_nx  = 1'b1;
    end

    if (wr_evt) begin
      if (!wr_a0 && wr_dat[4]) begin
        state_nx     = ST_ICW2;
        init_done_nx = 1'b0;
        imr_nx       = '0;
        smm_nx       = 1'b0;
        aeoi_nx      = 1'b0;
        upm_nx       = 1'b0;
        read_sel_nx  = 1'b0;
        poll_pend_nx = 1'b0;
        ltim_nx      = wr_dat[3];
        single_nx    = wr_dat[1];
        ic4_nx       = wr_dat[0];
      end else begin
        case (state)
          ST_ICW2: begin
            if (wr_a0) begin
              vec_base_nx = wr_dat[7:3];
              if (!single) begin
                state_nx = ST_ICW3;
              end else if (ic4) begin
                state_nx = ST_ICW4;
              end else begin
                state_nx     = ST_READY;
                init_done_nx = 1'b1;
              end
            end
          end
          ST_ICW3: begin
            if (wr_a0) begin
              cas_cfg_nx = wr_dat;
              if (ic4) begin
                state_nx = ST_ICW4;
              end else begin
                state_nx     = ST_READY;
                init_done_nx = 1'b1;
              end
            end
          end
          ST_ICW4: begin
            if (wr_a0) begin
              aeoi_nx      = wr_dat[1];
              upm_nx       = wr_dat[0];
              state_nx     = ST_READY;
              init_done_nx = 1'b1;
            end
          end
          ST_READY: begin
            if (wr_a0) begin
              imr_nx = wr_dat[N_IRQ-1:0];
            end else if (!wr_dat[3]) begin
              ocw2_stb_nx = 1'b1;
              ocw2_cmd_nx = wr_dat[7:5];
              ocw2_lvl_nx = wr_dat[2:0];
            end else begin
              if (wr_dat[1]) read_sel_nx  = wr_dat[0];
              if (wr_dat[6]) smm_nx       = wr_dat[5];
              if (wr_dat[2]) poll_pend_nx = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read-back mux; poll word takes priority, narrow registers zero-pad.
  always_comb begin
    rd_word = '0;
    if (poll_pend) begin
      rd_word = {poll_valid, 4'b0000, poll_level};
    end else if (a0_s) begin
      rd_word[N_IRQ-1:0] = imr;
    end else if (read_sel) begin
      rd_word[N_IRQ-1:0] = isr;
    end else begin
      rd_word[N_IRQ-1:0] = irr;
    end
    dout    = read_act ? rd_word : 8'h00;
    dout_oe = read_act;
  end

endmodule

// File: tb/tb_pic_bus_if.sv
// Bench for pic_bus_if: bus-level tasks against a transaction model.
// Runs an 8-channel and a 4-channel instance on the same bus.
module tb_pic_bus_if;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       cs_n = 1;
  logic       wr_n = 1;
  logic       rd_n = 1;
  logic       a0 = 0;
  logic [7:0] din = 0;
  logic [7:0] irr = 0;
  logic [7:0] isr = 0;
  logic       poll_valid = 0;
  logic [2:0] poll_level = 0;

  logic [7:0] dout, cas_cfg, dout4, cas4;
  logic       dout_oe, init_done, ltim, single, aeoi, upm, smm;
  logic       dout_oe4, done4, ltim4, single4, aeoi4, upm4, smm4;
  logic [7:0] imr;
  logic [3:0] imr4;
  logic [4:0] vec_base, vec4;
  logic       ocw2_stb, poll_stb, ostb4, pstb4;
  logic [2:0] ocw2_cmd, ocw2_lvl, ocmd4, olvl4;

  pic_bus_if #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n),
    .rd_n(rd_n), .a0(a0), .din(din), .dout(dout),
    .dout_oe(dout_oe), .irr(irr), .isr(isr),
    .poll_valid(poll_valid), .poll_level(poll_level),
    .imr(imr), .init_done(init_done), .ltim(ltim),
    .single(single), .vec_base(vec_base), .cas_cfg(cas_cfg),
    .aeoi(aeoi), .upm(upm), .smm(smm), .ocw2_stb(ocw2_stb),
    .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl),
    .poll_stb(poll_stb)
  );

  pic_bus_if #(.N_IRQ(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n),
    .rd_n(rd_n), .a0(a0), .din(din), .dout(dout4),
    .dout_oe(dout_oe4), .irr(irr[3:0]), .isr(isr[3:0]),
    .poll_valid(poll_valid), .poll_level(poll_level),
    .imr(imr4), .init_done(done4), .ltim(ltim4),
    .single(single4), .vec_base(vec4), .cas_cfg(cas4),
    .aeoi(aeoi4), .upm(upm4), .smm(smm4), .ocw2_stb(ostb4),
    .ocw2_cmd(ocmd4), .ocw2_lvl(olvl4), .poll_stb(pstb4)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_ocw2 = 0;
  int         n_poll = 0;
  logic [2:0] last_cmd = 0;
  logic [2:0] last_lvl = 0;

  always @(posedge clk) begin
    if (ocw2_stb) begin
      n_ocw2   <= n_ocw2 + 1;
      last_cmd <= ocw2_cmd;
      last_lvl <= ocw2_lvl;
    end
    if (poll_stb) n_poll <= n_poll + 1;
  end

  // Reference model: pending ICW bytes kept as a queue of numbers.
  int         pend[$];
  bit         m_done, m_ltim, m_single, m_aeoi, m_upm, m_smm;
  bit         m_sel_isr, m_poll;
  logic [7:0] m_imr, m_cas;
  logic [4:0] m_vec;
  int         e_ocw2 = 0;
  int         e_poll = 0;
  logic [2:0] e_cmd = 0;
  logic [2:0] e_lvl = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic void m_reset();
    pend.delete();
    m_done = 0; m_ltim = 0; m_single = 0; m_aeoi = 0;
    m_upm = 0; m_smm = 0; m_sel_isr = 0; m_poll = 0;
    m_imr = 8'hFF; m_cas = 0; m_vec = 0;
  endfunction

  function automatic void m_write(input bit wa0, input logic [7:0] d);
    int k;
    if (!wa0 && d[4]) begin
      pend.delete();
      pend.push_back(2);
      if (!d[1]) pend.push_back(3);
      if (d[0]) pend.push_back(4);
      m_done = 0; m_imr = 0; m_smm = 0; m_aeoi = 0; m_upm = 0;
      m_sel_isr = 0; m_poll = 0;
      m_ltim = d[3]; m_single = d[1];
    end else if (pend.size() > 0) begin
      if (wa0) begin
        k = pend.pop_front();
        if (k == 2) m_vec = d[7:3];
        if (k == 3) m_cas = d;
        if (k == 4) begin m_aeoi = d[1]; m_upm = d[0]; end
        if (pend.size() == 0) m_done = 1;
      end
    end else if (m_done) begin
      if (wa0) m_imr = d;
      else if (!d[3]) begin
        e_ocw2++; e_cmd = d[7:5]; e_lvl = d[2:0];
      end else begin
        if (d[1]) m_sel_isr = d[0];
        if (d[6]) m_smm = d[5];
        if (d[2]) m_poll = 1;
      end
    end
  endfunction

  function automatic logic [7:0] m_read(input bit ra0, input int n);
    logic [7:0] mask;
    mask = (n == 8) ? 8'hFF : 8'h0F;
    if (m_poll) return {poll_valid, 4'b0000, poll_level};
    if (ra0) return m_imr & mask;
    return (m_sel_isr ? isr : irr) & mask;
  endfunction

  task automatic check_cfg();
    chk("imr", imr, m_imr);
    chk("imr4", imr4, m_imr[3:0]);
    chk("init_done", init_done, m_done);
    chk("init_done4", done4, m_done);
    chk("ltim", ltim, m_ltim);
    chk("single", single, m_single);
    chk("vec_base", vec_base, m_vec);
    chk("cas_cfg", cas_cfg, m_cas);
    chk("aeoi", aeoi, m_aeoi);
    chk("upm", upm, m_upm);
    chk("smm", smm, m_smm);
    chk("ocw2_cnt", n_ocw2, e_ocw2);
    chk("ocw2_cmd", last_cmd, e_cmd);
    chk("ocw2_lvl", last_lvl, e_lvl);
    chk("poll_cnt", n_poll, e_poll);
  endtask

  task automatic bus_write(input bit wa0, input logic [7:0] d);
    @(negedge clk);
    a0 = wa0; din = d; cs_n = 0;
    @(negedge clk);
    wr_n = 0;
    repeat (3) @(negedge clk);
    wr_n = 1;
    @(negedge clk);
    cs_n = 1;
    repeat (6) @(negedge clk);
    m_write(wa0, d);
    check_cfg();
  endtask

  task automatic bus_read(input bit ra0);
    @(negedge clk);
    a0 = ra0; cs_n = 0; rd_n = 0;
    repeat (4) @(negedge clk);
    chk("rd_oe", dout_oe, 1);
    chk("rd_oe4", dout_oe4, 1);
    chk("rd_data", dout, m_read(ra0, 8));
    chk("rd_data4", dout4, m_read(ra0, 4));
    rd_n = 1; cs_n = 1;
    if (m_poll) begin m_poll = 0; e_poll++; end
    repeat (5) @(negedge clk);
    chk("idle_oe", dout_oe, 0);
    chk("idle_dout", dout, 0);
    chk("poll_cnt", n_poll, e_poll);
  endtask

  task automatic wr_latency(input logic [7:0] d);
    logic [7:0] old;
    old = imr;
    @(negedge clk);
    a0 = 1; din = d; cs_n = 0;
    @(negedge clk);
    wr_n = 0;
    repeat (3) @(negedge clk);
    wr_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("lat_early", imr, old);
    @(posedge clk);
    #1 chk("lat_commit", imr, d);
    @(negedge clk);
    cs_n = 1;
    repeat (4) @(negedge clk);
    m_write(1, d);
    check_cfg();
  endtask

  task automatic wr_and_rd(input bit wa0, input logic [7:0] d);
    @(negedge clk);
    a0 = wa0; din = d; cs_n = 0;
    @(negedge clk);
    wr_n = 0; rd_n = 0;
    repeat (4) @(negedge clk);
    chk("both_oe", dout_oe, 0);
    wr_n = 1; rd_n = 1;
    @(negedge clk);
    cs_n = 1;
    repeat (6) @(negedge clk);
    m_write(wa0, d);
    check_cfg();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 0;
    #1 chk("rst_imr_async", imr, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_reset();
    repeat (4) @(negedge clk);
    check_cfg();
    chk("rst_oe", dout_oe, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ocw2_stb", ocw2_stb, 0);
    chk("rst_poll_stb", poll_stb, 0);
  endtask

  task automatic reset_mid_strobe();
    @(negedge clk);
    a0 = 0; din = 8'h13; cs_n = 0;
    @(negedge clk);
    wr_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_reset();
    repeat (3) @(negedge clk);
    wr_n = 1;
    @(negedge clk);
    cs_n = 1;
    repeat (6) @(negedge clk);
    check_cfg();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check_cfg();
    chk("rst_oe", dout_oe, 0);
    chk("rst_dout", dout, 0);
    bus_read(1);

    bus_write(0, 8'h13);
    bus_write(1, 8'h40);
    chk("skip_icw3", init_done, 0);
    bus_write(1, 8'h03);
    chk("vec_08", vec_base, 5'h08);

    bus_write(0, 8'h11);
    bus_write(1, 8'h20);
    bus_read(1);
    bus_write(1, 8'h04);
    chk("done_late", init_done, 0);
    bus_write(1, 8'h01);

    wr_latency(8'hA5);
    bus_read(1);

    bus_write(0, 8'h0B);
    isr = 8'h10; irr = 8'h5A;
    bus_read(0);
    bus_read(0);
    bus_write(0, 8'h0A);
    bus_read(0);

    bus_write(0, 8'h20);
    chk("eoi_cmd", last_cmd, 3'b001);

    bus_write(0, 8'h68);
    bus_write(0, 8'h0C);
    poll_valid = 1; poll_level = 3'd5;
    bus_read(0);
    bus_read(0);

    wr_and_rd(1, 8'h3C);
    bus_read(1);

    bus_write(0, 8'h10);
    bus_write(1, 8'h48);
    bus_write(0, 8'h13);
    bus_write(1, 8'h50);
    bus_write(1, 8'h02);

    bus_write(0, 8'h11);
    reset_pulse();
    reset_mid_strobe();
    bus_read(1);

    for (int i = 0; i < 90; i++) begin
      irr = 8'($urandom);
      isr = 8'($urandom);
      poll_valid = 1'($urandom);
      poll_level = 3'($urandom);
      if ($urandom_range(0, 9) < 4) begin
        bus_read(1'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        bus_write(1'($urandom), 8'($urandom) & 8'hEF);
      end else begin
        bus_write(1'($urandom), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
